prom_loader: RTL

- Writer side of the 16-word x 15-bit program memory that the fetch stage reads by program counter.
- Receives instruction words as a byte stream over a valid/ready handshake and issues one-cycle write strobes to the memory's write port.
- Verifies a trailing XOR checksum byte.
- Holds the CPU (CPU_HOLD) while loading, so fetch never reads a partially written program.

---
 rtl/prom_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prom_loader.sv
// rtl/prom_loader.sv - byte-stream writer for the fetch-stage program memory with XOR checksum
module prom_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 15
) (
    input  logic          CLK_LD,
    input  logic          RESET_N,
    input  logic          START,
    input  logic [7:0]    BYTE_IN,
    input  logic          BYTE_VALID,
    output logic          BYTE_READY,
    output logic          W_EN,
    output logic [AW-1:0] W_ADDR,
    output logic [IW-1:0] W_DATA,
    output logic          CPU_HOLD,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WR, S_CK, S_FIN, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_d;
    logic [IW-1:0] data_d;
    logic [7:0]    csum_q, csum_d;
    logic          hold_d, done_d, err_d, ready_d, wen_d;
    logic          xfer;

    assign xfer = BYTE_VALID && BYTE_READY;

    always_comb begin
        state_d = state_q;
        addr_d  = W_ADDR;
        data_d  = W_DATA;
        csum_d  = csum_q;
        hold_d  = CPU_HOLD;
        done_d  = DONE;
        err_d   = ERR;
        case (state_q)
            S_IDLE, S_FIN, S_ERR: begin
                if (START) begin
                    state_d = S_HI;
                    addr_d  = '0;
                    csum_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            S_HI: begin
                if (xfer) begin
                    // A set bit 7 in a high byte means the stream is out of step.
                    if (BYTE_IN[7]) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        data_d[IW-1:8] = BYTE_IN[IW-9:0];
                        csum_d         = csum_q ^ BYTE_IN;
                        state_d        = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    data_d[7:0] = BYTE_IN;
                    csum_d      = csum_q ^ BYTE_IN;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (W_ADDR == AW'(DEPTH - 1)) begin
                    state_d = S_CK;
                end else begin
                    addr_d  = W_ADDR + 1'b1;
                    state_d = S_HI;
                end
            end
            S_CK: begin
                if (xfer) begin
                    hold_d = 1'b0;
                    if (BYTE_IN == csum_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe and ready are registered from the next state so they align with it.
    always_comb begin
        wen_d   = (state_d == S_WR);
        ready_d = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CK);
    end

    always_ff @(posedge CLK_LD or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            csum_q     <= '0;
            CPU_HOLD   <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            W_EN       <= 1'b0;
            BYTE_READY <= 1'b0;
        end else begin
            state_q    <= state_d;
            W_ADDR     <= addr_d;
            W_DATA     <= data_d;
            csum_q     <= csum_d;
            CPU_HOLD   <= hold_d;
            DONE       <= done_d;
            ERR        <= err_d;
            W_EN       <= wen_d;
            BYTE_READY <= ready_d;
        end
    end

endmodule
